// File: rtl/tile_pixel_pipe_if.sv
// Scan-position in, board/sprite memory lookups out and back, pixel colour out.
// Latency: none (signal bundle only).
// Backpressure: none; every signal is sampled or driven once per Clk.
interface tile_pixel_pipe_if;
    logic        pix_valid;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [7:0]  board_addr;
    logic [2:0]  board_data;
    logic [31:0] rom_address;
    logic [23:0] rom_data;
    logic [23:0] rgb;
    logic        rgb_valid;

    // Scan source plus the two memory models
    modport master (
        output pix_valid, draw_x, draw_y, board_data, rom_data,
        input  board_addr, rom_address, rgb, rgb_valid
    );

    // Pixel pipeline
    modport slave (
        input  pix_valid, draw_x, draw_y, board_data, rom_data,
        output board_addr, rom_address, rgb, rgb_valid
    );
endinterface

// File: rtl/tile_pixel_pipe.sv
// Tracks board cell / tile offset from the VGA scan and returns the aligned sprite or fill colour.
// Latency: 3 Clk edges from pix_valid to rgb_valid; throughput 1 pixel per cycle.
// Backpressure: none; bubbles (pix_valid=0) flow through as rgb_valid=0.
module tile_pixel_pipe #(
    parameter int          BOARD_X0  = 240,
    parameter int          BOARD_Y0  = 40,
    parameter int          TILE      = 20,
    parameter int          COLS      = 10,
    parameter int          ROWS      = 20,
    parameter logic [23:0] BG_RGB    = 24'h000000,
    parameter logic [23:0] EMPTY_RGB = 24'h202020
) (
    input  logic           Clk,
    input  logic           Reset_n,
    tile_pixel_pipe_if.slave pix_if
);

    localparam int TW = $clog2(TILE);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = $clog2(TILE * TILE);

    localparam logic [9:0]    X_LO    = 10'(BOARD_X0);
    localparam logic [9:0]    X_HI    = 10'(BOARD_X0 + COLS * TILE);
    localparam logic [9:0]    Y_LO    = 10'(BOARD_Y0);
    localparam logic [9:0]    Y_HI    = 10'(BOARD_Y0 + ROWS * TILE);
    localparam logic [TW-1:0] T_MAX   = TW'(TILE - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    // Position of the most recent in-board pixel
    logic [TW-1:0] r_tx;
    logic [CW-1:0] r_col;
    logic [TW-1:0] r_ty;
    logic [RW-1:0] r_row;

    // Position of the pixel on the inputs this cycle
    logic [TW-1:0] w_tx;
    logic [CW-1:0] w_col;
    logic [TW-1:0] w_ty;
    logic [RW-1:0] w_row;

    logic          w_in_board;
    logic          w_upd;
    logic [7:0]    w_board_addr;
    logic [AW-1:0] w_rom_addr;

    logic [7:0]    r_board_addr;
    logic [AW-1:0] r_rom_addr;
    logic          r_v1, r_b1, r_v2, r_b2;
    logic [23:0]   r_rgb;
    logic          r_rgb_valid;

    assign w_in_board = (pix_if.draw_x >= X_LO) && (pix_if.draw_x < X_HI) &&
                        (pix_if.draw_y >= Y_LO) && (pix_if.draw_y < Y_HI);
    assign w_upd      = pix_if.pix_valid && w_in_board;

    // Step the counters to this pixel: line start realigns x and steps y, otherwise x steps
    always_comb begin
        w_tx  = r_tx;
        w_col = r_col;
        w_ty  = r_ty;
        w_row = r_row;
        if (pix_if.draw_x == X_LO) begin
            w_tx  = '0;
            w_col = '0;
            if (pix_if.draw_y == Y_LO) begin
                w_ty  = '0;
                w_row = '0;
            end else if (r_ty == T_MAX) begin
                w_ty  = '0;
                w_row = (r_row == ROW_MAX) ? '0 : r_row + RW'(1);
            end else begin
                w_ty  = r_ty + TW'(1);
            end
        end else if (r_tx == T_MAX) begin
            w_tx  = '0;
            w_col = (r_col == COL_MAX) ? '0 : r_col + CW'(1);
        end else begin
            w_tx  = r_tx + TW'(1);
        end
    end

    // Multiply by small constants instead of dividing the scan position
    assign w_board_addr = 8'(w_row) * 8'(COLS) + 8'(w_col);
    assign w_rom_addr   = AW'(w_ty) * AW'(TILE) + AW'(w_tx);

    // S1: commit counters and issue memory addresses only for visible in-board pixels
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tx         <= '0;
            r_col        <= '0;
            r_ty         <= '0;
            r_row        <= '0;
            r_board_addr <= '0;
            r_rom_addr   <= '0;
            r_v1         <= 1'b0;
            r_b1         <= 1'b0;
        end else begin
            r_v1 <= pix_if.pix_valid;
            r_b1 <= w_in_board;
            if (w_upd) begin
                r_tx         <= w_tx;
                r_col        <= w_col;
                r_ty         <= w_ty;
                r_row        <= w_row;
                r_board_addr <= w_board_addr;
                r_rom_addr   <= w_rom_addr;
            end
        end
    end

    // S2: carry valid/in-board alongside the memory read cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_v2 <= 1'b0;
            r_b2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            r_b2 <= r_b1;
        end
    end

    // S3: pick background, empty-cell fill or sprite texel
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb       <= '0;
            r_rgb_valid <= 1'b0;
        end else begin
            r_rgb_valid <= r_v2;
            if (!r_b2)
                r_rgb <= BG_RGB;
            else if (pix_if.board_data == 3'd0)
                r_rgb <= EMPTY_RGB;
            else
                r_rgb <= pix_if.rom_data;
        end
    end

    assign pix_if.board_addr  = r_board_addr;
    assign pix_if.rom_address = 32'(r_rom_addr);
    assign pix_if.rgb         = r_rgb;
    assign pix_if.rgb_valid   = r_rgb_valid;

endmodule
